// File: rtl/led_status_pkg.sv
// Shared definitions for the multi-channel LED status PWM driver.
package led_status_pkg;

    typedef logic [1:0] mode_t;

    localparam mode_t MODE_OFF     = 2'd0;
    localparam mode_t MODE_ON      = 2'd1;
    localparam mode_t MODE_BLINK   = 2'd2;
    localparam mode_t MODE_BREATHE = 2'd3;

endpackage

// File: rtl/led_pwm_channel.sv
// One PWM output: shadow/active config, per-frame duty latch and the
// registered compare against the shared frame counter.
module led_pwm_channel
    import led_status_pkg::*;
#(
    parameter int PWM_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 xfer,
    input  logic [1:0]           mode_in,
    input  logic [PWM_WIDTH-1:0] level_in,
    input  logic                 boundary,
    input  logic                 load,
    input  logic                 blink_phase,
    input  logic [PWM_WIDTH-1:0] env,
    input  logic [PWM_WIDTH-1:0] pwm_cnt,
    input  logic                 asleep,
    output logic                 pwm
);

    mode_t                sh_mode, act_mode, nxt_mode;
    logic [PWM_WIDTH-1:0] sh_level, act_level, nxt_level;
    logic [PWM_WIDTH-1:0] duty, duty_sel;

    // config that will be active once this boundary completes
    assign nxt_mode  = load ? sh_mode  : act_mode;
    assign nxt_level = load ? sh_level : act_level;

    // duty for the coming frame from the post-boundary config, phase and envelope
    always_comb begin
        duty_sel = '0;
        case (nxt_mode)
            MODE_ON:      duty_sel = nxt_level;
            MODE_BLINK:   duty_sel = blink_phase ? '0 : nxt_level;
            MODE_BREATHE: duty_sel = (nxt_level < env) ? nxt_level : env;
            default:      duty_sel = '0;
        endcase
    end

    // shadow config captured on an accepted handshake
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sh_mode  <= MODE_OFF;
            sh_level <= '0;
        end else if (xfer) begin
            sh_mode  <= mode_in;
            sh_level <= level_in;
        end
    end

    // active config only changes at a frame boundary
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            act_mode  <= MODE_OFF;
            act_level <= '0;
        end else if (load) begin
            act_mode  <= sh_mode;
            act_level <= sh_level;
        end
    end

    // duty held for a whole frame so the output never glitches mid-frame
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) duty <= '0;
        else if (boundary) duty <= duty_sel;
    end

    // registered compare; sleep blanking takes effect in the same clk as asleep_o
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) pwm <= 1'b0;
        else pwm <= (pwm_cnt < duty) & ~asleep;
    end

endmodule

// File: rtl/led_status_pwm.sv
// Multi-channel LED status driver: shared prescaler, frame counter, blink and
// breathe generators, sleep blanking and the config handshake.
module led_status_pwm
    import led_status_pkg::*;
#(
    parameter int CHANNELS     = 3,
    parameter int PWM_WIDTH    = 8,
    parameter int TICK_DIV     = 188,
    parameter int BLINK_FRAMES = 32,
    parameter int SLEEP_FRAMES = 64
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic [2*CHANNELS-1:0]         mode_i,
    input  logic [PWM_WIDTH*CHANNELS-1:0] level_i,
    input  logic                          cfg_valid_i,
    output logic                          cfg_ready_o,
    input  logic                          sleep_i,
    output logic [CHANNELS-1:0]           pwm_o,
    output logic                          frame_o,
    output logic                          asleep_o
);

    localparam int PSC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int BLK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam int SLP_W = $clog2(SLEEP_FRAMES + 1);

    logic [PSC_W-1:0]     presc;
    logic                 tick, boundary;
    logic [PWM_WIDTH-1:0] pwm_cnt;
    logic [BLK_W-1:0]     blk_cnt, blk_cnt_nxt;
    logic                 blink_phase, blink_nxt;
    logic [PWM_WIDTH-1:0] env, env_nxt;
    logic                 env_up, env_up_nxt;
    logic                 sleep_m, sleep_s;
    logic [SLP_W-1:0]     slp_cnt, slp_nxt;
    logic                 asleep_nxt;
    logic                 pending, xfer, load;

    assign tick     = (presc == PSC_W'(TICK_DIV - 1));
    assign boundary = tick & (pwm_cnt == '1);

    // prescaler sets the PWM count rate
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) presc <= '0;
        else if (tick) presc <= '0;
        else presc <= presc + 1'b1;
    end

    // free-running PWM counter plus a registered frame-start pulse
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pwm_cnt <= '0;
            frame_o <= 1'b0;
        end else begin
            if (tick) pwm_cnt <= pwm_cnt + 1'b1;
            frame_o <= boundary;
        end
    end

    // post-boundary blink phase and triangle envelope, also fed to the channels
    always_comb begin
        blk_cnt_nxt = blk_cnt;
        blink_nxt   = blink_phase;
        env_nxt     = env;
        env_up_nxt  = env_up;
        if (boundary) begin
            if (blk_cnt == BLK_W'(BLINK_FRAMES - 1)) begin
                blk_cnt_nxt = '0;
                blink_nxt   = ~blink_phase;
            end else begin
                blk_cnt_nxt = blk_cnt + 1'b1;
            end
            if (env_up) begin
                if (env == '1) begin
                    env_nxt    = env - 1'b1;
                    env_up_nxt = 1'b0;
                end else begin
                    env_nxt = env + 1'b1;
                end
            end else begin
                if (env == '0) begin
                    env_nxt    = PWM_WIDTH'(1);
                    env_up_nxt = 1'b1;
                end else begin
                    env_nxt = env - 1'b1;
                end
            end
        end
    end

    // blink and envelope state
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            blk_cnt     <= '0;
            blink_phase <= 1'b0;
            env         <= '0;
            env_up      <= 1'b1;
        end else begin
            blk_cnt     <= blk_cnt_nxt;
            blink_phase <= blink_nxt;
            env         <= env_nxt;
            env_up      <= env_up_nxt;
        end
    end

    // two-flop synchroniser for the asynchronous sleep request
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) {sleep_s, sleep_m} <= 2'b00;
        else {sleep_s, sleep_m} <= {sleep_m, sleep_i};
    end

    // sleep must persist SLEEP_FRAMES boundaries before blanking; any gap reloads
    always_comb begin
        slp_nxt = slp_cnt;
        if (!sleep_s) slp_nxt = SLP_W'(SLEEP_FRAMES);
        else if (boundary && slp_cnt != '0) slp_nxt = slp_cnt - 1'b1;
    end
    assign asleep_nxt = (slp_nxt == '0);

    // sleep stretch counter and blanking flag
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            slp_cnt  <= '0;
            asleep_o <= 1'b0;
        end else begin
            slp_cnt  <= slp_nxt;
            asleep_o <= asleep_nxt;
        end
    end

    // single-entry handshake: one shadow update per frame, applied at the boundary
    assign cfg_ready_o = ~pending;
    assign xfer        = cfg_valid_i & cfg_ready_o;
    assign load        = boundary & pending;

    // pending set on accept, cleared when the shadow moves to active
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) pending <= 1'b0;
        else if (xfer) pending <= 1'b1;
        else if (boundary) pending <= 1'b0;
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        led_pwm_channel #(
            .PWM_WIDTH (PWM_WIDTH)
        ) u_ch (
            .clk         (clk),
            .rstn        (rstn),
            .xfer        (xfer),
            .mode_in     (mode_i[2*i +: 2]),
            .level_in    (level_i[PWM_WIDTH*i +: PWM_WIDTH]),
            .boundary    (boundary),
            .load        (load),
            .blink_phase (blink_nxt),
            .env         (env_nxt),
            .pwm_cnt     (pwm_cnt),
            .asleep      (asleep_nxt),
            .pwm         (pwm_o[i])
        );
    end

endmodule

// File: tb/tb_led_status_pwm.sv
// Scoreboard bench for led_status_pwm: the driver computes each cycle's expected
// outputs from a frame-level reference model; a monitor pops and compares.
module tb_led_status_pwm;

    localparam int CH = 3;
    localparam int W  = 4;
    localparam int TD = 1;
    localparam int BF = 2;
    localparam int SF = 3;
    localparam int FR = (2 ** W) * TD;
    localparam int EMAX = 2 ** W - 1;
    localparam int MW = 2 * CH;
    localparam int LW = W * CH;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic [MW-1:0] mode_i = '0;
    logic [LW-1:0] level_i = '0;
    logic          cfg_valid_i = 1'b0;
    logic          cfg_ready_o;
    logic          sleep_i = 1'b0;
    logic [CH-1:0] pwm_o;
    logic          frame_o;
    logic          asleep_o;

    always #5 clk = ~clk;

    led_status_pwm #(
        .CHANNELS     (CH),
        .PWM_WIDTH    (W),
        .TICK_DIV     (TD),
        .BLINK_FRAMES (BF),
        .SLEEP_FRAMES (SF)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .mode_i      (mode_i),
        .level_i     (level_i),
        .cfg_valid_i (cfg_valid_i),
        .cfg_ready_o (cfg_ready_o),
        .sleep_i     (sleep_i),
        .pwm_o       (pwm_o),
        .frame_o     (frame_o),
        .asleep_o    (asleep_o)
    );

    typedef struct packed {
        logic          frame;
        logic          ready;
        logic          asleep;
        logic [CH-1:0] pwm;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk = 0;
    int   n_err = 0;

    // reference model state (t = clk cycles since reset release)
    int            t;
    bit            hist[$];
    int            pend_end;
    bit            pend_vld;
    int            pend_n;
    logic [MW-1:0] pend_mode, act_mode;
    logic [LW-1:0] pend_lvl, act_lvl;
    int            prev_duty[CH];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s t=%0d actual=%0h required=%0h", name, t, act, exp);
        end
    endtask

    // envelope after boundary n: triangle 0..EMAX..0, period 2*EMAX
    function automatic int env_at(input int n);
        int p;
        p = n % (2 * EMAX);
        return (p <= EMAX) ? p : 2 * EMAX - p;
    endfunction

    function automatic int blink_at(input int n);
        return (n / BF) % 2;
    endfunction

    function automatic int duty_of(input logic [1:0] m, input int lvl, input int n);
        case (m)
            2'd1:    return lvl;
            2'd2:    return (blink_at(n) == 0) ? lvl : 0;
            2'd3:    return (lvl < env_at(n)) ? lvl : env_at(n);
            default: return 0;
        endcase
    endfunction

    // blanked once the synced sleep run has seen SF boundaries
    function automatic bit asleep_at(input int tc);
        int x, cnt;
        if (tc < 3) return 1'b0;
        if (!hist[tc-3]) return 1'b0;
        x = tc - 3;
        while (x > 0 && hist[x-1]) x--;
        cnt = 0;
        for (int b = x + 2; b <= tc - 1; b++)
            if (b % FR == FR - 1) cnt++;
        return (cnt >= SF);
    endfunction

    task automatic model_reset();
        t = 0;
        hist.delete();
        pend_end = -1;
        pend_vld = 1'b0;
        pend_n = 0;
        act_mode = '0;
        act_lvl = '0;
        for (int i = 0; i < CH; i++) prev_duty[i] = 0;
    endtask

    // drive one cycle, push its expected outputs, advance to next posedge+1
    task automatic cycle(input bit v, input logic [MW-1:0] m, input logic [LW-1:0] l, input bit s);
        exp_t e;
        int   n;
        int   d[CH];
        bit   rdy;
        cfg_valid_i = v;
        mode_i = m;
        level_i = l;
        sleep_i = s;
        hist.push_back(s);
        n = t / FR;
        if (pend_vld && n >= pend_n) begin
            act_mode = pend_mode;
            act_lvl = pend_lvl;
            pend_vld = 1'b0;
        end
        for (int i = 0; i < CH; i++) d[i] = duty_of(act_mode[2*i +: 2], int'(act_lvl[W*i +: W]), n);
        rdy = (t > pend_end);
        e.frame = (t > 0) && (t % FR == 0);
        e.ready = rdy;
        e.asleep = asleep_at(t);
        for (int i = 0; i < CH; i++)
            e.pwm[i] = (t > 0) && (((t - 1) % FR) < prev_duty[i]) && !e.asleep;
        if (v && rdy) begin
            pend_n = (t + 1) / FR + 1;
            pend_end = FR * pend_n - 1;
            pend_vld = 1'b1;
            pend_mode = m;
            pend_lvl = l;
        end
        prev_duty = d;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        t++;
    endtask

    task automatic do_reset(input int cycles);
        rstn = 1'b0;
        cfg_valid_i = 1'b0;
        sleep_i = 1'b0;
        for (int k = 0; k < cycles; k++) begin
            @(negedge clk);
            chk("rst_pwm", pwm_o, 0);
            chk("rst_frame", frame_o, 0);
            chk("rst_ready", cfg_ready_o, 1);
            chk("rst_asleep", asleep_o, 0);
            @(posedge clk);
            #1;
        end
        rstn = 1'b1;
        model_reset();
    endtask

    // monitor: compare every presented output cycle against the scoreboard
    initial begin : mon
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("frame", frame_o, e.frame);
                chk("ready", cfg_ready_o, e.ready);
                chk("asleep", asleep_o, e.asleep);
                chk("pwm", pwm_o, e.pwm);
            end
        end
    end

    initial begin : drv
        bit s;
        int run;
        model_reset();
        @(posedge clk);
        #1;
        do_reset(5);

        // idle frames, then ON/BLINK/BREATHE set mid-frame
        repeat (20) cycle(1'b0, '0, '0, 1'b0);
        cycle(1'b1, 6'b111001, 12'h8F4, 1'b0);
        // offers while pending must be ignored
        repeat (8) cycle(1'b1, MW'($urandom), LW'($urandom), 1'b0);
        repeat (170) cycle(1'b0, MW'($urandom), LW'($urandom), 1'b0);

        // short sleep: no visible effect
        repeat (16) cycle(1'b0, '0, '0, 1'b1);
        repeat (40) cycle(1'b0, '0, '0, 1'b0);
        // long sleep: blanking, then wake mid-frame
        repeat (64) cycle(1'b0, '0, '0, 1'b1);
        repeat (7) cycle(1'b0, '0, '0, 1'b0);
        repeat (40) cycle(1'b0, '0, '0, 1'b0);

        // handshake exactly on a boundary cycle
        while (t % FR != FR - 1) cycle(1'b0, '0, '0, 1'b0);
        cycle(1'b1, 6'b010101, 12'h3A7, 1'b0);
        repeat (40) cycle(1'b0, '0, '0, 1'b0);

        // random config offers and sleep runs
        s = 1'b0;
        run = 0;
        repeat (1500) begin
            if (run == 0) begin
                s = ($urandom_range(1, 0) == 1);
                run = $urandom_range(80, 5);
            end
            run--;
            cycle(($urandom_range(7, 0) == 0), MW'($urandom), LW'($urandom), s);
        end

        // reset with a config pending: it must be lost
        repeat (8) cycle(1'b0, '0, '0, 1'b0);
        while (t % FR != 3) cycle(1'b0, '0, '0, 1'b0);
        cycle(1'b1, 6'b011001, 12'hFFF, 1'b0);
        repeat (4) cycle(1'b0, '0, '0, 1'b0);
        do_reset(3);
        repeat (40) cycle(1'b0, MW'($urandom), LW'($urandom), 1'b0);

        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

endmodule
